// File: rtl/afifo_wptr_full.sv
// ---------------------------------------------------------------------------
// afifo_wptr_full
//
// Write-domain pointer and full-flag generator for an asynchronous FIFO.
// The write driver talks to this block directly. It gates each write request
// against the full flag, drives the memory write strobe and address, and
// publishes a Gray-coded write pointer to the read domain. The read domain's
// Gray pointer is brought into wclk through a SYNC_STAGES-deep flop chain.
// That synchronized copy is compared against the next write pointer to
// produce a registered full flag.
//
// Optional feature: define AFIFO_WR_ALMOST_FULL_EN to add the walmost_full
// output. This also adds the ALMOST_FULL_THRESH parameter, a Gray-to-binary
// converter on the synchronized read pointer, and a fill-level comparator.
// With the macro undefined, the port and that logic are absent.
//
// Parameters
//   ADDR_WIDTH          memory address width; depth = 2**ADDR_WIDTH (>= 2)
//   SYNC_STAGES         flop stages on the incoming read pointer (2..4)
//   ALMOST_FULL_THRESH  fill level at which walmost_full asserts (macro only)
//
// Ports
//   wclk          in   write-domain clock
//   wrst_n        in   synchronous active-low reset, sampled on posedge wclk
//   winc          in   write request from the producer
//   rptr          in   Gray read pointer from the read domain (ADDR_WIDTH+1)
//   wen           out  memory write strobe, combinational winc & ~wfull
//   waddr         out  memory write address (low bits of binary pointer)
//   wptr          out  registered Gray write pointer to the read domain
//   wfull         out  registered full flag
//   woverflow     out  one-cycle pulse per rejected write request
//   walmost_full  out  registered almost-full flag (macro only)
//
// Handshake: winc acts as the producer's valid and ~wfull as its ready. A
// write transfers on the posedge where winc=1 and wfull=0. A request made
// while wfull=1 is dropped, and woverflow pulses on the following cycle.
// ---------------------------------------------------------------------------
module afifo_wptr_full #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
`ifdef AFIFO_WR_ALMOST_FULL_EN
    ,
    parameter int ALMOST_FULL_THRESH = 2**ADDR_WIDTH - 2
`endif
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  woverflow
`ifdef AFIFO_WR_ALMOST_FULL_EN
    ,
    output logic                  walmost_full
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    // -----------------------------------------------------------------------
    // Read-pointer synchronizer. Stage 0 is the metastability-catching flop.
    // The last stage is the usable copy (wq_rptr).
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][PW-1:0] rsync_q;
    logic [PW-1:0]                  wq_rptr;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            rsync_q <= '0;
        end else begin
            rsync_q[0] <= rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rsync_q[i] <= rsync_q[i-1];
            end
        end
    end

    assign wq_rptr = rsync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Write pointer state and next-state logic
    // -----------------------------------------------------------------------
    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] full_match;
    logic          wfull_next;
    logic          woverflow_next;

    // wfull is a register, so the gate depends only on state and winc.
    // No path exists to accept a write into a full FIFO.
    assign wen   = winc & ~wfull;
    assign waddr = wbin[ADDR_WIDTH-1:0];

    // The addition wraps naturally at 2**PW. The MSB tells apart the two
    // laps that share the same memory address.
    assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wen};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // Full means the writer is exactly one lap ahead of the reader. In Gray
    // code, a one-lap offset inverts the top two bits and leaves the rest
    // unchanged.
    assign full_match     = {~wq_rptr[PW-1:PW-2], wq_rptr[PW-3:0]};
    assign wfull_next     = (wgray_next == full_match);
    assign woverflow_next = winc & wfull;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr      <= '0;
            wfull     <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr      <= wgray_next;
            wfull     <= wfull_next;
            woverflow <= woverflow_next;
        end
    end

`ifdef AFIFO_WR_ALMOST_FULL_EN
    // -----------------------------------------------------------------------
    // Almost-full: convert the synchronized read pointer back to binary,
    // then compare the post-write fill level against the threshold. Each
    // binary bit is the XOR of all Gray bits at and above it.
    // -----------------------------------------------------------------------
    localparam logic [PW-1:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

    logic [PW-1:0] wq_rbin;
    logic [PW-1:0] wlevel;

    always_comb begin
        wq_rbin = '0;
        for (int i = 0; i < PW; i++) begin
            wq_rbin[i] = ^(wq_rptr >> i);
        end
    end

    // Modulo-2**PW difference; the value never exceeds the depth.
    assign wlevel = wbin_next - wq_rbin;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            walmost_full <= 1'b0;
        end else begin
            walmost_full <= (wlevel >= AF_THRESH);
        end
    end
`endif

endmodule

// File: tb/tb_afifo_wptr_full.sv
// ---------------------------------------------------------------------------
// tb_afifo_wptr_full
//
// Bench for afifo_wptr_full with ADDR_WIDTH=4 and SYNC_STAGES=2. The
// reference model tracks plain integer counts of accepted writes and of
// reads. The reader count reaches the write domain through a delay queue
// that is SYNC_STAGES edges deep. Full means writes minus visible reads
// equals the depth. A scoreboard queue holds the expected address of every
// write the model accepts.
// ---------------------------------------------------------------------------
module tb_afifo_wptr_full;

    localparam int AW     = 4;
    localparam int SS     = 2;
    localparam int DEPTH  = 1 << AW;
    localparam int PMOD   = 1 << (AW + 1);
    localparam int THRESH = DEPTH - 2;

    // ---------------- clock / reset ----------------
    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          winc = 1'b0;
    logic [AW:0]   rptr = '0;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          woverflow;
`ifdef AFIFO_WR_ALMOST_FULL_EN
    logic          walmost_full;
`endif

    always #5 wclk = ~wclk;

    afifo_wptr_full #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS)
`ifdef AFIFO_WR_ALMOST_FULL_EN
        ,
        .ALMOST_FULL_THRESH (THRESH)
`endif
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .rptr         (rptr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .woverflow    (woverflow)
`ifdef AFIFO_WR_ALMOST_FULL_EN
        ,
        .walmost_full (walmost_full)
`endif
    );

    // ---------------- reference model state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    int            wr_cnt   = 0;   // accepted writes since reset
    int            rd_cnt   = 0;   // reads the reader has performed
    int            seen_q[$];      // reader counts in flight through sync
    logic          m_full   = 1'b0;
    logic          m_ovf    = 1'b0;
    logic          m_af     = 1'b0;
    logic [AW-1:0] exp_q[$];       // expected addresses of accepted writes

    function automatic logic [AW:0] to_gray(input int count);
        logic [AW:0] b;
        b = AW'(0) + (AW+1)'(count % PMOD);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver: one write-clock cycle ----------------
    task automatic step(input logic w, input logic rst_n_v, input logic rd_req);
        int seen;
        int level;
        @(negedge wclk);
        winc   = w;
        wrst_n = rst_n_v;
        if (!rst_n_v) rd_cnt = 0;
        else if (rd_req && rd_cnt < wr_cnt) rd_cnt++;
        rptr = to_gray(rd_cnt);
        #1;
        if (rst_n_v) begin
            check("wen", wen, w && !m_full);
            if (w && !m_full) exp_q.push_back(AW'(wr_cnt % DEPTH));
            if (wen) begin
                if (exp_q.size() == 0) check("spurious_wen", 1, 0);
                else check("wr_addr", waddr, exp_q.pop_front());
            end
        end
        @(posedge wclk);
        if (!rst_n_v) begin
            wr_cnt = 0;
            m_full = 1'b0;
            m_ovf  = 1'b0;
            m_af   = 1'b0;
            seen_q.delete();
            repeat (SS) seen_q.push_back(0);
        end else begin
            m_ovf = w && m_full;
            if (w && !m_full) wr_cnt++;
            seen = seen_q.pop_front();
            seen_q.push_back(rd_cnt);
            level  = wr_cnt - seen;
            m_full = (level == DEPTH);
            m_af   = (level >= THRESH);
        end
        #1;
        check("waddr", waddr, wr_cnt % DEPTH);
        check("wptr", wptr, to_gray(wr_cnt));
        check("wfull", wfull, m_full);
        check("woverflow", woverflow, m_ovf);
`ifdef AFIFO_WR_ALMOST_FULL_EN
        check("walmost_full", walmost_full, m_af);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (SS) seen_q.push_back(0);

        // Reset for 4 edges with rptr=0
        repeat (4) step(1'b0, 1'b0, 1'b0);
        check("rst_wptr", wptr, 0);
        check("rst_wfull", wfull, 0);

        // Fill 16 entries with no reads
        for (int i = 0; i < DEPTH; i++) begin
`ifdef AFIFO_WR_ALMOST_FULL_EN
            if (i == THRESH - 1) check("af_before", walmost_full, 0);
`endif
            step(1'b1, 1'b1, 1'b0);
`ifdef AFIFO_WR_ALMOST_FULL_EN
            if (i == THRESH - 1) check("af_at_thresh", walmost_full, 1);
`endif
            if (i < DEPTH - 1) check("fill_not_full", wfull, 0);
        end
        check("fill_wptr", wptr, 5'b11000);
        check("fill_waddr", waddr, 0);
        check("fill_full", wfull, 1);

        // Overflow: two rejected requests
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("ovf_wptr", wptr, 5'b11000);
        check("ovf_pulse", woverflow, 1);
        step(1'b0, 1'b1, 1'b0);
        check("ovf_clear", woverflow, 0);

        // Release: one read; wfull drops on the third edge
        step(1'b0, 1'b1, 1'b1);
        check("rel_e1", wfull, 1);
        step(1'b0, 1'b1, 1'b0);
        check("rel_e2", wfull, 1);
        step(1'b0, 1'b1, 1'b0);
        check("rel_e3", wfull, 0);
        step(1'b1, 1'b1, 1'b0);
        check("wrap_waddr", waddr, 1);
        check("wrap_wptr", wptr, 5'b11001);
        check("wrap_full", wfull, 1);

        // Reset in the middle of a burst
        step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("midrst_wptr", wptr, 0);
        check("midrst_waddr", waddr, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 299) != 0),
                 1'($urandom_range(0, 2) == 0));
        end

        check("exp_q_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/afifo_wptr_full.md
# afifo_wptr_full

Write-domain pointer and full-flag generator for the asynchronous FIFO. It is the block the write driver talks to directly: it takes `winc`, gates it against `wfull`, and produces the memory write enable and write address. It also produces the Gray-coded write pointer that is sent to the read domain. It synchronizes the read domain's Gray pointer into `wclk` and computes a registered `wfull`.

## Interface
- `ADDR_WIDTH`, 4: memory address width; FIFO depth = 2**ADDR_WIDTH.
- `SYNC_STAGES`, 2: flop stages on the incoming read pointer; legal range 2..4.
- `ALMOST_FULL_THRESH`, 2**ADDR_WIDTH-2: fill level at which `walmost_full` asserts. Used only when the macro is defined.

- `wclk`  in  1: write-domain clock.
- `wrst_n`  in  1: reset. Synchronous, active-low, sampled on posedge `wclk`.
- `winc`  in  1: write request from the producer.
- `rptr`  in  ADDR_WIDTH+1: read pointer, Gray-coded, launched from the read clock domain.
- `wen`  out  1: memory write strobe, combinational = `winc & ~wfull`.
- `waddr`  out  ADDR_WIDTH: memory write address = low bits of the binary write pointer.
- `wptr`  out  ADDR_WIDTH+1: registered Gray write pointer, sent to the read domain.
- `wfull`  out  1: registered full flag.
- `woverflow`  out  1: one-cycle pulse marking a write request that was rejected.
- `walmost_full`  out  1: registered almost-full flag. Present only with the macro.

## Operation
- State is held in these registers:
  - `wbin`: binary write pointer, ADDR_WIDTH+1 bits.
  - `wptr`: Gray write pointer.
  - `wfull`, `woverflow`.
  - Synchronizer chain: SYNC_STAGES × (ADDR_WIDTH+1) bits; the final stage is `wq_rptr`.
- Next-pointer logic:
  - `wbin_next = wbin + wen`. Addition wraps modulo 2**(ADDR_WIDTH+1).
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
- Full detection: `wfull_next` = (`wgray_next` == `wq_rptr` with its top two bits inverted and the remaining bits unchanged).
- Overflow: `woverflow_next = winc & wfull`.
  - A rejected write does not advance any pointer.
  - A rejected write does not assert `wen`.
- Full/empty wrap behaviour:
  - The MSB of the pointer distinguishes the two laps of the same address.
  - `waddr` wraps from 2**ADDR_WIDTH-1 to 0 with no gap cycle.
- Simultaneous events:
  - A write on the same edge that a new `rptr` arrives is always taken if `wfull` is 0. `wfull` is recomputed against the synchronized pointer.
  - Because of synchronizer latency, `wfull` is pessimistic. It may remain 1 for SYNC_STAGES+1 cycles after the reader frees space. This is legal.
- Reset:
  - With `wrst_n` low at a posedge, all registers clear on that edge, including synchronizer stages. This holds even in the middle of a burst.
  - A `winc` held during reset is ignored.
  - `wen` = 0 while `wfull` is 0 and `winc` is 0. During reset, the driver holds `winc` low.

## Timing
- Reset values: `wptr`=0, `waddr`=0, `wfull`=0, `woverflow`=0, `walmost_full`=0, `wen`=0 (given `winc`=0).
- Write acceptance:
  - A write is accepted on the posedge where `winc`=1 and `wfull`=0.
  - `waddr` and `wptr` update on that same edge.
- Full assertion:
  - `wfull` is 1 immediately after the edge that accepts the 2**ADDR_WIDTH-th unread entry.
  - No cycle exists in which a write into a full FIFO could be accepted.
- Full release: `rptr` change to `wfull` deassert is SYNC_STAGES edges of synchronization plus 1 edge for the flag register. That is 3 edges at the default setting.
- `woverflow` asserts the edge after the rejected request and lasts 1 cycle per rejected request.
- `rptr` must change by at most one Gray step per read clock. The block relies on this and does not check it.

## Configuration
- `AFIFO_WR_ALMOST_FULL_EN` defined:
  - Adds port `walmost_full` and a Gray-to-binary converter on `wq_rptr`.
  - `level = wbin_next - wq_rbin`, computed modulo 2**(ADDR_WIDTH+1).
  - `walmost_full` is registered as `level >= ALMOST_FULL_THRESH`.
- Macro undefined: the port, the converter and the comparator are absent. All other behaviour is identical.

## Test plan
All scenarios use ADDR_WIDTH=4 and SYNC_STAGES=2.
- Reset: `wrst_n`=0 for 4 edges with `rptr`=0 → `wptr`=0, `waddr`=0, `wfull`=0, `woverflow`=0.
- Fill: 16 consecutive `winc` with `rptr`=0 → `waddr` steps 0..15 then reads 0; `wptr`=5'b11000; `wfull`=1 immediately after the 16th accepted edge.
- Overflow: `winc`=1 for 2 cycles while full → `wen`=0, `woverflow` high for 2 cycles, `wptr` stays 5'b11000.
- Release and wrap: from full, set `rptr`=5'b00001 → `wfull`=0 three edges later. Then one write → `waddr` goes 0→1, `wptr`=5'b11001, and `wfull`=1 again.
- Reset mid-burst: after 5 writes, pull `wrst_n` low for 1 edge with `winc`=1 → `wptr`=0, `waddr`=0, and no write is accepted on the reset edge.
- Almost full: macro defined, ALMOST_FULL_THRESH=14, `rptr`=0 → `walmost_full`=1 after the 14th write and `wfull`=0 until the 16th.
